muldiv_unit: RTL and testbench

- Parametrised, iterative RV32M/RV64M multiply/divide execution unit for the core's EX stage.
- Accepts one operation at a time over a start/ready handshake.
- Computes the result serially, one bit per cycle, and returns it with its destination-register tag.
- The control unit stalls the pipeline while `busy` is high.
- Generalises the single-cycle ALU path to XLEN-wide, multi-cycle, killable operations.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, killable,
// result returned with its destination tag as a single-cycle done pulse.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             kill,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned AW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               raw_q, raw_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [TAG_W-1:0]   rd_out_q, rd_out_d;

    // Operand sign decode and magnitude conversion at accept time
    logic            s1_signed, s2_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs, spec_res;

    always_comb begin
        s1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg     = s1_signed && rs1[XLEN-1];
        b_neg     = s2_signed && rs2[XLEN-1];
        a_abs     = a_neg ? -rs1 : rs1;
        b_abs     = b_neg ? -rs2 : rs2;
        div_zero  = (rs2 == '0);
        div_ovf   = op[2] && !op[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        if (div_zero) spec_res = op[1] ? rs1 : '1;
        else          spec_res = op[1] ? '0  : rs1;
    end

    // One iteration of shift-add multiply and restoring divide
    logic [XLEN:0]   mul_sum, div_r, div_t;
    logic            div_ge;
    logic [AW-1:0]   mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_r    = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
        div_t    = div_r - {1'b0, b_q};
        div_ge   = !div_t[XLEN];
        div_next = {(div_ge ? div_t[XLEN-1:0] : div_r[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end

    // Sign fix-up of the finished product / quotient / remainder
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quo_f, rem_f, fin;

    always_comb begin
        prod  = qneg_q ? -acc_q : acc_q;
        quo_f = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_f = rneg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
        if (raw_q)              fin = acc_q[XLEN-1:0];
        else if (!op_q[2])      fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[AW-1:XLEN];
        else                    fin = op_q[1] ? rem_f : quo_f;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        raw_d    = raw_q;
        done_d   = 1'b0;
        result_d = '0;
        rd_out_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    rd_d   = rd_in;
                    b_d    = b_abs;
                    acc_d  = {{XLEN{1'b0}}, a_abs};
                    cnt_d  = CNT_W'(XLEN);
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    raw_d  = 1'b0;
                    if (op[2] && (div_zero || div_ovf)) begin
                        raw_d   = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, spec_res};
                        state_d = S_DONE;
                    end else begin
                        state_d = op[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = fin;
                rd_out_d = rd_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle request
        if (kill) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = '0;
            rd_out_d = '0;
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            raw_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            raw_q    <= raw_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        start, kill, ready, busy, done;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  rd_in, rd_out;

    logic        start64, kill64, ready64, busy64, done64;
    logic [2:0]  op64;
    logic [63:0] rs1_64, rs2_64, result64;
    logic [4:0]  rd_in64, rd_out64;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t exp64_q[$];
    bit   prev_done = 0;
    bit   prev_done64 = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .rd_in(rd_in), .kill(kill), .ready(ready), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .op(op64), .rs1(rs1_64), .rs2(rs2_64),
        .rd_in(rd_in64), .kill(kill64), .ready(ready64), .busy(busy64), .done(done64),
        .result(result64), .rd_out(rd_out64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit instance: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) chk("pulse32", 64'(done), 64'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done32: result 0x%0h rd %0d", result, rd_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result32", 64'(result), e.res);
                    chk("rd32", 64'(rd_out), 64'(e.rd));
                    chk("latency32", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
            end
            prev_done = done;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (prev_done64) chk("pulse64", 64'(done64), 64'd0);
            if (done64) begin
                if (exp64_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done64: result 0x%0h rd %0d", result64, rd_out64);
                end else begin
                    exp_t e;
                    e = exp64_q.pop_front();
                    chk("result64", result64, e.res);
                    chk("rd64", 64'(rd_out64), 64'(e.rd));
                    chk("latency64", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
            end
            prev_done64 = done64;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input bit expect_done);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout32: ready stayed 0 for %0d cycles", n);
            return;
        end
        start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = rd;
        if (expect_done) exp_q.push_back('{64'(res), rd, lat, cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd, input logic [63:0] res);
        int n = 0;
        @(negedge clk);
        while (!ready64 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready64) begin
            total++;
            bad++;
            $display("FAIL ready_timeout64: ready stayed 0 for %0d cycles", n);
            return;
        end
        start64 = 1'b1; op64 = o; rs1_64 = a; rs2_64 = b; rd_in64 = rd;
        exp64_q.push_back('{res, rd, 66, cyc});
        @(negedge clk);
        start64 = 1'b0;
    endtask

    vec_t vecs[14] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
        '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
        '{3'b001, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 34},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
        '{3'b101, 32'd100,       32'd7,         32'd14,        34},
        '{3'b111, 32'd100,       32'd7,         32'd2,         34},
        '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2},
        '{3'b110, 32'd5,         32'd0,         32'd5,         2},
        '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2}
    };

    initial begin
        reset = 1'b0; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        start64 = 1'b0; kill64 = 1'b0; op64 = '0; rs1_64 = '0; rs2_64 = '0; rd_in64 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rd_out", 64'(rd_out), 64'd0);
        chk("rst_ready64", 64'(ready64), 64'd1);

        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res, vecs[i].lat, 1'b1);

        // Kill a DIVU mid-flight; a request in the same cycle must be dropped
        issue(3'b101, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1; start = 1'b1; op = 3'b000; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd21;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        chk("kill_ready", 64'(ready), 64'd1);
        chk("kill_busy", 64'(busy), 64'd0);
        chk("kill_result", 64'(result), 64'd0);
        issue(3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 34, 1'b1);

        // Asynchronous reset in the middle of a multiply
        issue(3'b000, 32'd5, 32'd6, 5'd23, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue64(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
                64'hFFFF_FFFF_FFFF_FFFE);
        issue64(3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd18, 64'hFFFF_FFFF_FFFF_FFF2);

        for (int n = 0; n < 500 && (exp_q.size() != 0 || exp64_q.size() != 0); n++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        chk("pending32", 64'(exp_q.size()), 64'd0);
        chk("pending64", 64'(exp64_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
